// File: rtl/sample_rate_interpolator.sv
// rtl/sample_rate_interpolator.sv - linear-interpolating sample-rate upconverter
//
// Purpose: accepts signed low-rate samples and emits INTERP_FACTOR linearly
// interpolated samples per input, y_k = prev + floor(k*(cur-prev)/INTERP_FACTOR).
// Single clock, enable-gated; no derived clocks.
//
// Ports:
//   clk_in     sole clock
//   rst        asynchronous active-high reset
//   enable     global advance qualifier; 0 freezes all state
//   flush      synchronous clear of history and pipeline
//   data_in    low-rate signed input sample
//   valid_in   data_in valid
//   ready_in   input accepted this cycle (combinational)
//   data_out   interpolated signed sample (registered)
//   valid_out  data_out valid (registered)
//   ready_out  downstream accepts data_out
module sample_rate_interpolator #(
  parameter int DATA_WIDTH    = 16,
  parameter int INTERP_FACTOR = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int LOG2L = $clog2(INTERP_FACTOR);
  localparam int PW    = DATA_WIDTH + 1 + LOG2L;
  localparam logic [LOG2L-1:0] LAST_PHASE = LOG2L'(INTERP_FACTOR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_n;
  logic [DATA_WIDTH-1:0]  prev, prev_n;
  logic [DATA_WIDTH-1:0]  cur, cur_n;
  logic [DATA_WIDTH-1:0]  data_out_n;
  logic [LOG2L-1:0]       phase, phase_n;
  logic                   valid_out_n;
  logic                   out_adv;
  logic                   in_xfer;
  logic                   last_phase;
  logic signed [DATA_WIDTH:0] delta;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   step;
  logic [DATA_WIDTH-1:0]  y;

  assign out_adv    = enable && (!valid_out || ready_out);
  assign last_phase = (phase == LAST_PHASE);
  assign ready_in   = enable && !flush &&
                      ((state == IDLE) || (state == RUN && last_phase && out_adv));
  assign in_xfer    = valid_in && ready_in;

  // One extra bit keeps cur-prev exact across the full signed range; the
  // product gets LOG2L more so k*delta cannot overflow before the shift.
  assign delta = $signed({cur[DATA_WIDTH-1], cur}) - $signed({prev[DATA_WIDTH-1], prev});
  assign prod  = $signed({{LOG2L{delta[DATA_WIDTH]}}, delta}) *
                 $signed({{(DATA_WIDTH+1){1'b0}}, phase});
  // Arithmetic shift rounds toward minus infinity (floor), not toward zero.
  assign step  = prod >>> LOG2L;
  // Result lies between prev and cur, so dropping the upper bits is exact.
  assign y     = DATA_WIDTH'($signed({{(LOG2L+1){prev[DATA_WIDTH-1]}}, prev}) + step);

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    cur_n       = cur;
    phase_n     = phase;
    data_out_n  = data_out;
    valid_out_n = valid_out;
    if (flush) begin
      state_n     = IDLE;
      prev_n      = '0;
      cur_n       = '0;
      phase_n     = '0;
      valid_out_n = 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (out_adv) valid_out_n = 1'b0;
          // prev already holds the previous sample; only cur is loaded.
          if (in_xfer) begin
            cur_n   = data_in;
            phase_n = '0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (out_adv) begin
            data_out_n  = y;
            valid_out_n = 1'b1;
            if (!last_phase) begin
              phase_n = phase + LOG2L'(1);
            end else begin
              prev_n  = cur;
              phase_n = '0;
              if (in_xfer) cur_n = data_in;
              else         state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= '0;
      cur       <= '0;
      phase     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      cur       <= cur_n;
      phase     <= phase_n;
      data_out  <= data_out_n;
      valid_out <= valid_out_n;
    end
  end

endmodule

// File: tb/tb_sample_rate_interpolator.sv
// tb/tb_sample_rate_interpolator.sv - scoreboard bench for sample_rate_interpolator
module tb_sample_rate_interpolator;

  localparam int DW = 16;
  localparam int L  = 4;

  logic          clk_in = 1'b0;
  logic          rst, enable, flush, valid_in, ready_in, valid_out, ready_out;
  logic [DW-1:0] data_in, data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int got_q[$];
  bit vo_hist[$];
  int exp_list[$];
  int p_model = 0;
  int mon_e, mon_x;
  bit hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  sample_rate_interpolator #(.DATA_WIDTH(DW), .INTERP_FACTOR(L)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .flush    (flush),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_out(ready_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(int n, int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model: each accepted sample x expands into L points on the
  // straight line from the previous accepted sample to x.
  always @(negedge clk_in) begin
    if (rst) begin
      exp_q.delete();
      p_model   = 0;
      hold_prev = 1'b0;
    end else begin
      vo_hist.push_back(valid_out);
      if (hold_prev) begin
        check("hold_valid", int'(valid_out), 1);
        check("hold_data", $signed(data_out), $signed(hold_data));
      end
      if (enable && valid_out && ready_out) begin
        got_q.push_back($signed(data_out));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", $signed(data_out));
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", $signed(data_out), mon_e);
        end
      end
      if (flush) begin
        exp_q.delete();
        p_model = 0;
      end else if (valid_in && ready_in) begin
        mon_x = $signed(data_in);
        for (int k = 0; k < L; k++)
          exp_q.push_back(p_model + floor_div(k * (mon_x - p_model), L));
        p_model = mon_x;
      end
      hold_prev = valid_out && !ready_out && !flush;
      hold_data = data_out;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(int x);
    bit acc;
    acc      = 1'b0;
    valid_in = 1'b1;
    data_in  = DW'(x);
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk_in);
      acc = ready_in;
      @(posedge clk_in);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: sample %0d not accepted, expected acceptance within 50 cycles", x);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_seq(string name);
    check({name, "_count"}, got_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < got_q.size(); i++)
      check(name, got_q[i], exp_list[i]);
  endtask

  initial begin
    int ones, runs, gap_ok;
    rst = 1'b1; enable = 1'b1; flush = 1'b0; valid_in = 1'b0;
    data_in = '0; ready_out = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_data_out", $signed(data_out), 0);
    check("reset_valid_out", int'(valid_out), 0);
    rst = 1'b0;
    tick();
    check("idle_ready_in", int'(ready_in), 1);

    // Ramp up from reset, gapless
    got_q.delete(); vo_hist.delete();
    send(100); send(200); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 25, 50, 75, 100, 125, 150, 175};
    check_seq("ramp");
    ones = 0; runs = 0;
    for (int i = 0; i < vo_hist.size(); i++) begin
      if (vo_hist[i]) ones++;
      if (vo_hist[i] && (i == 0 || !vo_hist[i-1])) runs++;
    end
    check("ramp_valid_cycles", ones, 8);
    check("ramp_valid_runs", runs, 1);

    // Negative step, floor rounding
    do_flush(); got_q.delete();
    send(100); send(-100); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 25, 50, 75, 100, 50, 0, -50};
    check_seq("neg_step");
    do_flush(); got_q.delete();
    send(-1); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, -1, -1, -1};
    check_seq("floor_minus1");

    // Full scale
    do_flush(); got_q.delete();
    send(-32768); send(32767); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, -8192, -16384, -24576, -32768, -16385, -1, 16383};
    check_seq("full_scale");

    // Backpressure at phase 2
    do_flush(); got_q.delete();
    send(40); data_in = DW'(80);
    tick(); tick();
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("bp_data", $signed(data_out), 10);
      check("bp_valid", int'(valid_out), 1);
      check("bp_ready_in", int'(ready_in), 0);
      @(posedge clk_in);
      #1;
    end
    ready_out = 1'b1;
    send(80); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 10, 20, 30, 40, 50, 60, 70};
    check_seq("backpressure");

    // Idle gap
    do_flush(); got_q.delete();
    send(40); valid_in = 1'b0;
    wait_drain();
    gap_ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (ready_in && !valid_out) gap_ok++;
      @(posedge clk_in);
      #1;
    end
    check("gap_idle_cycles", gap_ok, 10);
    send(80); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 10, 20, 30, 40, 50, 60, 70};
    check_seq("idle_gap");

    // enable freeze mid-group
    do_flush(); got_q.delete();
    send(40); data_in = DW'(80);
    tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("freeze_data", $signed(data_out), 10);
      check("freeze_valid", int'(valid_out), 1);
      check("freeze_ready_in", int'(ready_in), 0);
      @(posedge clk_in);
      #1;
    end
    enable = 1'b1;
    send(80); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 10, 20, 30, 40, 50, 60, 70};
    check_seq("enable_freeze");

    // flush together with valid_in while an output is pending
    do_flush();
    send(100); valid_in = 1'b0;
    tick();
    valid_in = 1'b1; data_in = DW'(55); flush = 1'b1;
    @(negedge clk_in);
    check("flush_ready_in", int'(ready_in), 0);
    @(posedge clk_in);
    #1;
    flush = 1'b0; valid_in = 1'b0;
    check("flush_valid_out", int'(valid_out), 0);
    got_q.delete();
    send(8); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 2, 4, 6};
    check_seq("after_flush");

    // Asynchronous reset mid-group
    do_flush();
    send(40); valid_in = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_data_out", $signed(data_out), 0);
    check("rst_valid_out", int'(valid_out), 0);
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    send(20); valid_in = 1'b0;
    wait_drain();
    exp_list = '{0, 5, 10, 15};
    check_seq("after_rst");

    // Randomized traffic against the model
    do_flush();
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      ready_out = ($urandom_range(0, 3) != 0);
      valid_in  = ($urandom_range(0, 2) != 0);
      data_in   = DW'($urandom);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0; valid_in = 1'b0; enable = 1'b1; ready_out = 1'b1;
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
